// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I core: datapath width, ALU control codes and
// the main-decoder ALU op encodings consumed by the ID->EX stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_CTRL_AND = 4'd0;
  localparam logic [3:0] ALU_CTRL_OR  = 4'd1;
  localparam logic [3:0] ALU_CTRL_ADD = 4'd2;
  localparam logic [3:0] ALU_CTRL_SUB = 4'd6;
  localparam logic [3:0] ALU_CTRL_SLT = 4'd7;
  localparam logic [3:0] ALU_CTRL_NOR = 4'd12;
  localparam logic [3:0] ALU_CTRL_ILL = 4'd15;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/riscv_alu_ctrl.sv
// Combinational ALU control decoder: maps the main-decoder ALU op plus funct
// fields onto a 4-bit ALU control code, flagging unsupported combinations.
module riscv_alu_ctrl
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       rtype,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_CTRL_ILL;
    illegal  = 1'b1;
    case (alu_op)
      ALUOP_ADD: begin
        alu_ctrl = ALU_CTRL_ADD;
        illegal  = 1'b0;
      end
      ALUOP_SUB: begin
        alu_ctrl = ALU_CTRL_SUB;
        illegal  = 1'b0;
      end
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only selects SUB for R-type; for ADDI it is an immediate bit
          F3_ADDSUB: begin
            alu_ctrl = (rtype && funct7b5) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
            illegal  = 1'b0;
          end
          F3_AND: begin
            alu_ctrl = ALU_CTRL_AND;
            illegal  = 1'b0;
          end
          F3_OR: begin
            alu_ctrl = ALU_CTRL_OR;
            illegal  = 1'b0;
          end
          F3_SLT: begin
            alu_ctrl = ALU_CTRL_SLT;
            illegal  = 1'b0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_id_ex_stage.sv
// ID->EX pipeline register: decodes ALU control, selects operand B, and holds
// beats in a main register backed by a skid entry so in_ready comes from a flop.
module riscv_id_ex_stage #(
  parameter int unsigned XLEN    = riscv_pkg::XLEN,
  parameter int unsigned REGADDR = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_alu_src,
  input  logic [1:0]         in_alu_op,
  input  logic [2:0]         in_funct3,
  input  logic               in_funct7b5,
  input  logic               in_rtype,
  input  logic [REGADDR-1:0] in_rd,
  input  logic               in_reg_write,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    A,
  output logic [XLEN-1:0]    B,
  output logic [3:0]         ALU_Ctrl,
  output logic [REGADDR-1:0] out_rd,
  output logic               out_reg_write,
  output logic [XLEN-1:0]    out_pc,
  output logic               illegal
);

  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [XLEN-1:0]    pc;
    logic [3:0]         alu_ctrl;
    logic [REGADDR-1:0] rd;
    logic               reg_write;
    logic               illegal;
  } payload_t;

  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  payload_t   beat;
  payload_t   main_q, main_d, skid_q, skid_d;
  logic       main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic       accept, pop;

  riscv_alu_ctrl u_alu_ctrl (
    .alu_op   (in_alu_op),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .rtype    (in_rtype),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  always_comb begin
    beat.a         = in_rs1;
    beat.b         = in_alu_src ? in_imm : in_rs2;
    beat.pc        = in_pc;
    beat.alu_ctrl  = dec_ctrl;
    beat.rd        = in_rd;
    beat.reg_write = in_reg_write & ~dec_illegal;
    beat.illegal   = dec_illegal;
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_valid_q && !pop) begin
      // main is stalled; skid is empty whenever accept is possible
      if (accept) begin
        skid_d       = beat;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      main_d       = beat;
      main_valid_d = 1'b1;
    end else begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid     = main_valid_q;
  assign A             = main_q.a;
  assign B             = main_q.b;
  assign ALU_Ctrl      = main_q.alu_ctrl;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.reg_write;
  assign out_pc        = main_q.pc;
  assign illegal       = main_q.illegal;

endmodule

// File: tb/tb_riscv_id_ex_stage.sv
// Scoreboard bench for riscv_id_ex_stage: directed decode vectors, backpressure,
// flush, mid-stream reset and a 100-beat streaming run.
module tb_riscv_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic        in_alu_src, in_funct7b5, in_rtype, in_reg_write;
  logic [1:0]  in_alu_op;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [31:0] A, B, out_pc;
  logic [3:0]  ALU_Ctrl;
  logic [4:0]  out_rd;
  logic        out_reg_write, illegal;

  always #5 clk = ~clk;

  riscv_id_ex_stage dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_imm        (in_imm),
    .in_alu_src    (in_alu_src),
    .in_alu_op     (in_alu_op),
    .in_funct3     (in_funct3),
    .in_funct7b5   (in_funct7b5),
    .in_rtype      (in_rtype),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .A             (A),
    .B             (B),
    .ALU_Ctrl      (ALU_Ctrl),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .out_pc        (out_pc),
    .illegal       (illegal)
  );

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic       rtype;
    logic       src;
    logic [3:0] ctrl;
    logic       ill;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } beat_t;

  typedef struct {
    beat_t b;
    int    cyc;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_popped = 0;
  int   cyc_cnt  = 0;
  bit   lat_chk  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: a beat leaves whenever out_valid & out_ready at the coming edge
  always @(negedge clk) begin
    beat_t act;
    exp_t  e;
    if (!reset && !flush && out_valid && out_ready) begin
      act = {A, B, out_pc, ALU_Ctrl, out_rd, out_reg_write, illegal};
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got %0h expected no beat", act);
      end else begin
        e = sb.pop_front();
        chk("beat", act, e.b);
        if (lat_chk) chk("latency", cyc_cnt - e.cyc, 1);
      end
      n_popped++;
    end
  end

  task automatic apply(input int v, input int tag);
    in_rs1       = 32'h1000_0000 + 32'(tag);
    in_rs2       = 32'd5 + 32'(tag);
    in_imm       = 32'hFFFF_FFF0 - 32'(tag);
    in_pc        = 32'(tag * 4);
    in_rd        = 5'(tag);
    in_reg_write = 1'b1;
    in_alu_src   = vecs[v].src;
    in_alu_op    = vecs[v].op;
    in_funct3    = vecs[v].f3;
    in_funct7b5  = vecs[v].f7b5;
    in_rtype     = vecs[v].rtype;
    in_valid     = 1'b1;
  endtask

  function automatic beat_t expect_of(input int v, input int tag);
    beat_t e;
    e.a    = 32'h1000_0000 + 32'(tag);
    e.b    = vecs[v].src ? 32'hFFFF_FFF0 - 32'(tag) : 32'd5 + 32'(tag);
    e.pc   = 32'(tag * 4);
    e.ctrl = vecs[v].ctrl;
    e.rd   = 5'(tag);
    e.rw   = ~vecs[v].ill;
    e.ill  = vecs[v].ill;
    return e;
  endfunction

  // Offer a beat and hold it until the handshake edge; leaves in_valid high
  task automatic send(input int v, input int tag, output int waited);
    exp_t e;
    apply(v, tag);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else begin
      e.b   = expect_of(v, tag);
      e.cyc = cyc_cnt;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int n0;
    vecs[0] = '{2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 4'd2,  1'b0};
    vecs[1] = '{2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 4'd6,  1'b0};
    vecs[2] = '{2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 4'd6,  1'b0};
    vecs[3] = '{2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 4'd2,  1'b0};
    vecs[4] = '{2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0};
    vecs[5] = '{2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 4'd1,  1'b0};
    vecs[6] = '{2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 4'd7,  1'b0};
    vecs[7] = '{2'b10, 3'b001, 1'b0, 1'b1, 1'b0, 4'd15, 1'b1};
    vecs[8] = '{2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1};
    vecs[9] = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 4'd2,  1'b0};

    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    apply(0, 0);
    in_valid = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_ctrl", ALU_Ctrl, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_b", B, 0);
    chk("rst_reg_write", out_reg_write, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Decode and operand-B vectors, no backpressure
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    for (int v = 0; v < 10; v++) send(v, 0, w);
    in_valid = 1'b0;
    drain();

    // Backpressure: two beats held, third waits for release
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(2, 1, w);
    send(4, 2, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    apply(5, 3);
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(5, 3, w);
    in_valid = 1'b0;
    drain();

    // Flush with main and skid full and a beat on offer
    out_ready = 1'b0;
    send(0, 4, w);
    send(1, 5, w);
    apply(6, 6);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    n0 = n_popped;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_no_beat", n_popped - n0, 0);

    // Asynchronous reset in the middle of a held stream
    out_ready = 1'b0;
    send(2, 7, w);
    send(3, 8, w);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_alu_ctrl", ALU_Ctrl, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_a", A, 0);
    chk("midrst_pc", out_pc, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Streaming: one beat per cycle, one-cycle latency, never stalled
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    n0 = n_popped;
    for (int i = 0; i < 100; i++) begin
      send(i % 10, i + 16, w);
      chk("stream_no_stall", w, 0);
    end
    in_valid = 1'b0;
    drain();
    chk("stream_beats", n_popped - n0, 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
